// File: rtl/snitch_icache_miss_handler.sv
// rtl/snitch_icache_miss_handler.sv - icache miss handler: hit return, pending refill tracking, RAM fill and response
// Optional secondary-miss merging into a pending entry: define SNITCH_ICACHE_MISS_MERGE_EN.
module snitch_icache_miss_handler #(
   parameter int unsigned FetchAw      = 32,
   parameter int unsigned LineWidth    = 128,
   parameter int unsigned LineAlign    = 4,
   parameter int unsigned CountAlign   = 5,
   parameter int unsigned SetCount     = 2,
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned PendingCount = 2,
   parameter int unsigned SetAlign     = (SetCount > 1) ? $clog2(SetCount) : 1,
   parameter int unsigned PendAlign    = (PendingCount > 1) ? $clog2(PendingCount) : 1,
   parameter int unsigned TagWidth     = FetchAw - LineAlign - CountAlign
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [FetchAw-1:0]    in_addr_i,
   input  logic [IdWidth-1:0]    in_id_i,
   input  logic                  in_hit_i,
   input  logic [LineWidth-1:0]  in_data_i,
   input  logic                  in_error_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [LineWidth-1:0]  rsp_data_o,
   output logic                  rsp_error_o,
   output logic [IdWidth-1:0]    rsp_id_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [FetchAw-1:0]    refill_addr_o,
   output logic [PendAlign-1:0]  refill_id_o,
   output logic                  refill_valid_o,
   input  logic                  refill_ready_i,
   input  logic [LineWidth-1:0]  refill_data_i,
   input  logic                  refill_error_i,
   input  logic [PendAlign-1:0]  refill_id_i,
   input  logic                  refill_valid_i,
   output logic                  refill_ready_o,
   output logic [CountAlign-1:0] write_addr_o,
   output logic [SetAlign-1:0]   write_set_o,
   output logic [TagWidth-1:0]   write_tag_o,
   output logic [LineWidth-1:0]  write_data_o,
   output logic                  write_error_o,
   output logic                  write_valid_o,
   input  logic                  write_ready_i
);
   localparam int unsigned LineAw = FetchAw - LineAlign;

   typedef enum logic [1:0] {FillIdle, FillWrite, FillResp} fill_state_e;

   logic [PendingCount-1:0] ent_valid_q, ent_pend_q;
   logic [LineAw-1:0]       ent_line_q [PendingCount];
   logic [IdWidth-1:0]      ent_mask_q [PendingCount];

   fill_state_e             state_q;
   logic [LineWidth-1:0]    fill_data_q;
   logic                    fill_error_q;
   logic [PendAlign-1:0]    fill_id_q;
   logic [SetAlign-1:0]     victim_q;

   logic                    rsp_valid_q, rsp_error_q;
   logic [LineWidth-1:0]    rsp_data_q;
   logic [IdWidth-1:0]      rsp_id_q;

   logic                    refill_lock_q;
   logic [PendAlign-1:0]    refill_idx_q;

   logic [LineAw-1:0]       in_line;
   logic                    match_any, free_any, pend_any;
   logic [PendAlign-1:0]    match_idx, free_idx, pend_idx, refill_sel;
   logic                    rsp_free, resp_fire, hit_ok, miss_ok, hit_fire, miss_fire;
   logic                    unused_addr;

   assign in_line     = in_addr_i[FetchAw-1:LineAlign];
   assign unused_addr = ^in_addr_i[LineAlign-1:0];

   // Descending scan so the lowest matching / free / pending index wins.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      free_any  = 1'b0;
      free_idx  = '0;
      pend_any  = 1'b0;
      pend_idx  = '0;
      for (int i = int'(PendingCount) - 1; i >= 0; i--) begin
         if (ent_valid_q[i] && (ent_line_q[i] == in_line)) begin
            match_any = 1'b1;
            match_idx = PendAlign'(i);
         end
         if (!ent_valid_q[i]) begin
            free_any = 1'b1;
            free_idx = PendAlign'(i);
         end
         if (ent_pend_q[i]) begin
            pend_any = 1'b1;
            pend_idx = PendAlign'(i);
         end
      end
   end

   assign rsp_free  = !rsp_valid_q || rsp_ready_i;
   assign resp_fire = (state_q == FillResp) && rsp_free;
   assign hit_ok    = rsp_free && (state_q != FillResp);

`ifdef SNITCH_ICACHE_MISS_MERGE_EN
   assign miss_ok = match_any ? !((state_q == FillResp) && (fill_id_q == match_idx)) : free_any;
`else
   assign miss_ok = !match_any && free_any;
`endif

   assign in_ready_o = rst_ni && (in_hit_i ? hit_ok : miss_ok);
   assign hit_fire   = in_valid_i && in_ready_o && in_hit_i;
   assign miss_fire  = in_valid_i && in_ready_o && !in_hit_i;

   // A presented request keeps its index until accepted, even if a lower entry becomes pending.
   assign refill_sel     = refill_lock_q ? refill_idx_q : pend_idx;
   assign refill_valid_o = pend_any;
   assign refill_id_o    = refill_sel;
   assign refill_addr_o  = {ent_line_q[refill_sel], {LineAlign{1'b0}}};
   assign refill_ready_o = rst_ni && (state_q == FillIdle);

   assign write_valid_o = (state_q == FillWrite);
   assign write_addr_o  = ent_line_q[fill_id_q][CountAlign-1:0];
   assign write_tag_o   = ent_line_q[fill_id_q][LineAw-1:CountAlign];
   assign write_set_o   = victim_q;
   assign write_data_o  = fill_data_q;
   assign write_error_o = fill_error_q;

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_error_o = rsp_error_q;
   assign rsp_id_o    = rsp_id_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ent_valid_q   <= '0;
         ent_pend_q    <= '0;
         for (int i = 0; i < int'(PendingCount); i++) begin
            ent_line_q[i] <= '0;
            ent_mask_q[i] <= '0;
         end
         state_q       <= FillIdle;
         fill_data_q   <= '0;
         fill_error_q  <= 1'b0;
         fill_id_q     <= '0;
         victim_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_error_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_id_q      <= '0;
         refill_lock_q <= 1'b0;
         refill_idx_q  <= '0;
      end else begin
         refill_lock_q <= refill_valid_o && !refill_ready_i;
         refill_idx_q  <= refill_sel;
         if (refill_valid_o && refill_ready_i) begin
            ent_pend_q[refill_sel] <= 1'b0;
         end

         case (state_q)
            FillIdle: begin
               if (refill_valid_i) begin
                  fill_data_q  <= refill_data_i;
                  fill_error_q <= refill_error_i;
                  fill_id_q    <= refill_id_i;
                  state_q      <= FillWrite;
               end
            end
            FillWrite: begin
               if (write_ready_i) begin
                  victim_q <= (victim_q == SetAlign'(SetCount - 1)) ? '0 : victim_q + 1'b1;
                  state_q  <= FillResp;
               end
            end
            FillResp: begin
               if (rsp_free) begin
                  state_q <= FillIdle;
               end
            end
            default: state_q <= FillIdle;
         endcase

         // The fill response owns the response register over the hit path.
         if (resp_fire) begin
            rsp_valid_q            <= 1'b1;
            rsp_data_q             <= fill_data_q;
            rsp_error_q            <= fill_error_q;
            rsp_id_q               <= ent_mask_q[fill_id_q];
            ent_valid_q[fill_id_q] <= 1'b0;
         end else if (hit_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= in_data_i;
            rsp_error_q <= in_error_i;
            rsp_id_q    <= in_id_i;
         end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end

         // Allocation only targets entries invalid this cycle, so it never collides with a free.
         if (miss_fire) begin
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
            if (match_any) begin
               ent_mask_q[match_idx] <= ent_mask_q[match_idx] | in_id_i;
            end else begin
               ent_valid_q[free_idx] <= 1'b1;
               ent_pend_q[free_idx]  <= 1'b1;
               ent_line_q[free_idx]  <= in_line;
               ent_mask_q[free_idx]  <= in_id_i;
            end
`else
            ent_valid_q[free_idx] <= 1'b1;
            ent_pend_q[free_idx]  <= 1'b1;
            ent_line_q[free_idx]  <= in_line;
            ent_mask_q[free_idx]  <= in_id_i;
`endif
         end
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (refill_valid_i && refill_ready_o) |-> ent_valid_q[refill_id_i]);

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// tb/tb_snitch_icache_miss_handler.sv - directed self-checking bench for snitch_icache_miss_handler
module tb_snitch_icache_miss_handler;
   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [31:0]   in_addr_i;
   logic [3:0]    in_id_i;
   logic          in_hit_i;
   logic [127:0]  in_data_i;
   logic          in_error_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [127:0]  rsp_data_o;
   logic          rsp_error_o;
   logic [3:0]    rsp_id_o;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [31:0]   refill_addr_o;
   logic [0:0]    refill_id_o;
   logic          refill_valid_o;
   logic          refill_ready_i;
   logic [127:0]  refill_data_i;
   logic          refill_error_i;
   logic [0:0]    refill_id_i;
   logic          refill_valid_i;
   logic          refill_ready_o;
   logic [4:0]    write_addr_o;
   logic [0:0]    write_set_o;
   logic [22:0]   write_tag_o;
   logic [127:0]  write_data_o;
   logic          write_error_o;
   logic          write_valid_o;
   logic          write_ready_i;

   int vectors = 0;
   int miscompares = 0;

   snitch_icache_miss_handler dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_addr_i(in_addr_i), .in_id_i(in_id_i), .in_hit_i(in_hit_i), .in_data_i(in_data_i),
      .in_error_i(in_error_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .refill_addr_o(refill_addr_o), .refill_id_o(refill_id_o), .refill_valid_o(refill_valid_o),
      .refill_ready_i(refill_ready_i), .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
      .refill_id_i(refill_id_i), .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
      .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_tag_o(write_tag_o),
      .write_data_o(write_data_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
      .write_ready_i(write_ready_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0; in_valid_i = 1'b0; in_hit_i = 1'b0; in_addr_i = '0; in_id_i = '0;
      in_data_i = '0; in_error_i = 1'b0; rsp_ready_i = 1'b1; refill_ready_i = 1'b0;
      refill_valid_i = 1'b0; refill_data_i = '0; refill_error_i = 1'b0; refill_id_i = '0;
      write_ready_i = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic send(input logic [31:0] a, input logic [3:0] id, input logic hit,
                       input logic [127:0] d, input logic e, output logic ok);
      int n = 0;
      in_addr_i = a; in_id_i = id; in_hit_i = hit; in_data_i = d; in_error_i = e; in_valid_i = 1'b1;
      #1;
      while (!in_ready_o && n < 50) begin
         @(posedge clk_i); #2; n++;
      end
      ok = in_ready_o;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic take_req(output logic [31:0] a, output logic [0:0] id, output logic ok);
      int n = 0;
      while (!refill_valid_o && n < 50) begin tick(); n++; end
      ok = refill_valid_o; a = refill_addr_o; id = refill_id_o;
      refill_ready_i = 1'b1; tick(); refill_ready_i = 1'b0;
   endtask

   task automatic give_rsp(input logic [0:0] id, input logic [127:0] d, input logic e, output logic ok);
      int n = 0;
      refill_id_i = id; refill_data_i = d; refill_error_i = e; refill_valid_i = 1'b1;
      while (!refill_ready_o && n < 50) begin tick(); n++; end
      ok = refill_ready_o;
      tick(); refill_valid_i = 1'b0;
   endtask

   task automatic take_write(output logic [4:0] a, output logic [0:0] s, output logic [22:0] t,
                             output logic [127:0] d, output logic e, output logic ok);
      int n = 0;
      while (!write_valid_o && n < 50) begin tick(); n++; end
      ok = write_valid_o; a = write_addr_o; s = write_set_o; t = write_tag_o; d = write_data_o; e = write_error_o;
      write_ready_i = 1'b1; tick(); write_ready_i = 1'b0;
   endtask

   task automatic wait_rsp(output logic [3:0] id, output logic [127:0] d, output logic e, output logic ok);
      int n = 0;
      while (!rsp_valid_o && n < 50) begin tick(); n++; end
      ok = rsp_valid_o; id = rsp_id_o; d = rsp_data_o; e = rsp_error_o;
   endtask

   task automatic test_reset();
      do_reset();
      rst_ni = 1'b0; tick();
      vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid_o); end
      vectors++; if (refill_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_refill_valid: got %0b want 0", refill_valid_o); end
      vectors++; if (write_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_write_valid: got %0b want 0", write_valid_o); end
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 0", in_ready_o); end
      vectors++; if (refill_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_refill_ready: got %0b want 0", refill_ready_o); end
      vectors++; if (refill_addr_o !== 32'h0) begin miscompares++; $display("FAIL reset_refill_addr: got %h want 0", refill_addr_o); end
      vectors++; if (write_set_o !== 1'b0) begin miscompares++; $display("FAIL reset_write_set: got %0d want 0", write_set_o); end
      vectors++; if (rsp_data_o !== 128'h0) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
      rst_ni = 1'b1; tick();
      vectors++; if (refill_ready_o !== 1'b1) begin miscompares++; $display("FAIL post_reset_refill_ready: got %0b want 1", refill_ready_o); end
   endtask

   task automatic test_hit();
      logic ok;
      logic [127:0] d = {4{32'hcafe_0001}};
      send(32'h1000, 4'b0001, 1'b1, d, 1'b0, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL hit_accept: got %0b want 1", ok); end
      vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL hit_rsp_valid: got %0b want 1", rsp_valid_o); end
      vectors++; if (rsp_id_o !== 4'b0001) begin miscompares++; $display("FAIL hit_rsp_id: got %b want 0001", rsp_id_o); end
      vectors++; if (rsp_data_o !== d) begin miscompares++; $display("FAIL hit_rsp_data: got %h want %h", rsp_data_o, d); end
      vectors++; if (refill_valid_o !== 1'b0) begin miscompares++; $display("FAIL hit_no_refill: got %0b want 0", refill_valid_o); end
      tick();
      vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL hit_rsp_drain: got %0b want 0", rsp_valid_o); end
   endtask

   task automatic test_miss();
      logic ok; logic [31:0] a; logic [0:0] id; logic [4:0] wa; logic [0:0] ws; logic [22:0] wt;
      logic [127:0] wd, rd; logic we, re; logic [3:0] rid;
      logic [127:0] d2 = {4{32'h2222_beef}};
      send(32'h2040, 4'b0001, 1'b0, '0, 1'b0, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL miss_accept: got %0b want 1", ok); end
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h2040 || id !== 1'b0) begin miscompares++; $display("FAIL miss_req: got ok=%0b addr=%h id=%0d want ok=1 addr=2040 id=0", ok, a, id); end
      give_rsp(1'b0, d2, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      vectors++; if (ok !== 1'b1 || wa !== 5'h04 || wt !== 23'h10 || ws !== 1'b0) begin miscompares++; $display("FAIL miss_write: got ok=%0b addr=%h tag=%h set=%0d want 1/04/10/0", ok, wa, wt, ws); end
      vectors++; if (wd !== d2 || we !== 1'b0) begin miscompares++; $display("FAIL miss_write_data: got %h err=%0b want %h err=0", wd, we, d2); end
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0001 || rd !== d2) begin miscompares++; $display("FAIL miss_rsp: got ok=%0b id=%b data=%h want id=0001 data=%h", ok, rid, rd, d2); end
      tick();
   endtask

   task automatic test_secondary_miss();
      logic ok; logic [31:0] a; logic [0:0] id; logic [4:0] wa; logic [0:0] ws; logic [22:0] wt;
      logic [127:0] wd, rd; logic we, re; logic [3:0] rid;
      logic [127:0] d3 = {4{32'h3333_0000}};
      send(32'h3000, 4'b0001, 1'b0, '0, 1'b0, ok);
`ifdef SNITCH_ICACHE_MISS_MERGE_EN
      send(32'h3008, 4'b0100, 1'b0, '0, 1'b0, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL merge_accept: got %0b want 1", ok); end
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h3000 || id !== 1'b0) begin miscompares++; $display("FAIL merge_req: got ok=%0b addr=%h id=%0d want 3000/0", ok, a, id); end
      vectors++; if (refill_valid_o !== 1'b0) begin miscompares++; $display("FAIL merge_single_req: got %0b want 0", refill_valid_o); end
      give_rsp(1'b0, d3, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0101 || rd !== d3) begin miscompares++; $display("FAIL merge_rsp: got ok=%0b id=%b data=%h want id=0101", ok, rid, rd); end
      tick();
`else
      in_addr_i = 32'h3008; in_id_i = 4'b0100; in_hit_i = 1'b0; in_valid_i = 1'b1;
      #1;
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL nomerge_stall: got %0b want 0", in_ready_o); end
      #1;
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h3000 || id !== 1'b0) begin miscompares++; $display("FAIL nomerge_req1: got ok=%0b addr=%h id=%0d want 3000/0", ok, a, id); end
      give_rsp(1'b0, d3, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0001) begin miscompares++; $display("FAIL nomerge_rsp1: got ok=%0b id=%b want 0001", ok, rid); end
      vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL nomerge_unstall: got %0b want 1", in_ready_o); end
      tick(); in_valid_i = 1'b0;
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h3000 || id !== 1'b0) begin miscompares++; $display("FAIL nomerge_req2: got ok=%0b addr=%h id=%0d want 3000/0", ok, a, id); end
      give_rsp(1'b0, d3, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0100) begin miscompares++; $display("FAIL nomerge_rsp2: got ok=%0b id=%b want 0100", ok, rid); end
      tick();
`endif
   endtask

   task automatic test_capacity();
      logic ok; logic [31:0] a; logic [0:0] id; logic [4:0] wa; logic [0:0] ws; logic [22:0] wt;
      logic [127:0] wd, rd; logic we, re; logic [3:0] rid;
      send(32'h4000, 4'b0001, 1'b0, '0, 1'b0, ok);
      send(32'h5000, 4'b0010, 1'b0, '0, 1'b0, ok);
      in_addr_i = 32'h6000; in_id_i = 4'b0100; in_hit_i = 1'b0; in_valid_i = 1'b1;
      #1;
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_stall: got %0b want 0", in_ready_o); end
      #1;
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h4000 || id !== 1'b0) begin miscompares++; $display("FAIL full_req0: got ok=%0b addr=%h id=%0d want 4000/0", ok, a, id); end
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h5000 || id !== 1'b1) begin miscompares++; $display("FAIL full_req1: got ok=%0b addr=%h id=%0d want 5000/1", ok, a, id); end
      vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_still_stall: got %0b want 0", in_ready_o); end
      give_rsp(1'b0, {4{32'h4444_4444}}, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0001) begin miscompares++; $display("FAIL full_rsp0: got ok=%0b id=%b want 0001", ok, rid); end
      vectors++; if (in_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_unstall: got %0b want 1", in_ready_o); end
      tick(); in_valid_i = 1'b0;
      take_req(a, id, ok);
      vectors++; if (ok !== 1'b1 || a !== 32'h6000 || id !== 1'b0) begin miscompares++; $display("FAIL full_req_third: got ok=%0b addr=%h id=%0d want 6000/0", ok, a, id); end
      give_rsp(1'b1, {4{32'h5555_5555}}, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0010) begin miscompares++; $display("FAIL full_rsp1: got ok=%0b id=%b want 0010", ok, rid); end
      tick();
      give_rsp(1'b0, {4{32'h6666_6666}}, 1'b0, ok);
      take_write(wa, ws, wt, wd, we, ok);
      wait_rsp(rid, rd, re, ok);
      vectors++; if (ok !== 1'b1 || rid !== 4'b0100) begin miscompares++; $display("FAIL full_rsp_third: got ok=%0b id=%b want 0100", ok, rid); end
      tick();
   endtask

   task automatic test_error_victim();
      logic ok; logic [31:0] a; logic [0:0] id; logic [4:0] wa; logic [0:0] ws; logic [22:0] wt;
      logic [127:0] wd, rd; logic we, re; logic [3:0] rid;
      logic [31:0]  addr_t [3] = '{32'h8000, 32'h9000, 32'ha000};
      logic [22:0]  tag_t  [3] = '{23'h40, 23'h48, 23'h50};
      logic         err_t  [3] = '{1'b1, 1'b0, 1'b0};
      logic [0:0]   set_t  [3] = '{1'b0, 1'b1, 1'b0};
      logic [127:0] dat_t  [3] = '{{4{32'ha0a0_0000}}, {4{32'hb1b1_1111}}, {4{32'hc2c2_2222}}};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         send(addr_t[k], 4'b1000, 1'b0, '0, 1'b0, ok);
         take_req(a, id, ok);
         give_rsp(id, dat_t[k], err_t[k], ok);
         take_write(wa, ws, wt, wd, we, ok);
         vectors++; if (ok !== 1'b1 || ws !== set_t[k] || wt !== tag_t[k] || wa !== 5'h0) begin miscompares++; $display("FAIL fill%0d_write: got ok=%0b set=%0d tag=%h addr=%h want set=%0d tag=%h addr=0", k, ok, ws, wt, wa, set_t[k], tag_t[k]); end
         vectors++; if (we !== err_t[k] || wd !== dat_t[k]) begin miscompares++; $display("FAIL fill%0d_write_err: got err=%0b data=%h want err=%0b", k, we, wd, err_t[k]); end
         wait_rsp(rid, rd, re, ok);
         vectors++; if (ok !== 1'b1 || re !== err_t[k] || rd !== dat_t[k] || rid !== 4'b1000) begin miscompares++; $display("FAIL fill%0d_rsp: got ok=%0b err=%0b id=%b want err=%0b id=1000", k, ok, re, rid, err_t[k]); end
         tick();
      end
   endtask

   task automatic test_rsp_backpressure();
      logic ok;
      logic [127:0] d3 = {4{32'hd3d3_0003}};
      logic [127:0] d4 = {4{32'hd4d4_0004}};
      rsp_ready_i = 1'b0;
      send(32'h1100, 4'b0010, 1'b1, d3, 1'b0, ok);
      in_addr_i = 32'h1200; in_id_i = 4'b1000; in_hit_i = 1'b1; in_data_i = d4; in_valid_i = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         vectors++; if (in_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp%0d_in_ready: got %0b want 0", c, in_ready_o); end
         vectors++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== d3 || rsp_id_o !== 4'b0010) begin miscompares++; $display("FAIL bp%0d_rsp_stable: got v=%0b id=%b data=%h want v=1 id=0010 data=%h", c, rsp_valid_o, rsp_id_o, rsp_data_o, d3); end
         @(posedge clk_i); #2;
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      vectors++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== d4 || rsp_id_o !== 4'b1000) begin miscompares++; $display("FAIL bp_next_hit: got v=%0b id=%b data=%h want v=1 id=1000 data=%h", rsp_valid_o, rsp_id_o, rsp_data_o, d4); end
      tick();
   endtask

   task automatic test_reset_mid_write();
      logic ok; logic [31:0] a; logic [0:0] id;
      send(32'h7000, 4'b0001, 1'b0, '0, 1'b0, ok);
      take_req(a, id, ok);
      give_rsp(id, {4{32'h7777_7777}}, 1'b0, ok);
      vectors++; if (write_valid_o !== 1'b1) begin miscompares++; $display("FAIL midwrite_in_write: got %0b want 1", write_valid_o); end
      send(32'h7400, 4'b0010, 1'b0, '0, 1'b0, ok);
      vectors++; if (refill_valid_o !== 1'b1 || write_valid_o !== 1'b1) begin miscompares++; $display("FAIL midwrite_setup: got refill_v=%0b write_v=%0b want 1/1", refill_valid_o, write_valid_o); end
      rst_ni = 1'b0;
      tick();
      vectors++; if (write_valid_o !== 1'b0 || refill_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL midwrite_reset_valids: got w=%0b rf=%0b rsp=%0b want 0/0/0", write_valid_o, refill_valid_o, rsp_valid_o); end
      rst_ni = 1'b1;
      tick();
      vectors++; if (refill_ready_o !== 1'b1) begin miscompares++; $display("FAIL midwrite_fsm_idle: got %0b want 1", refill_ready_o); end
      send(32'h7000, 4'b0001, 1'b0, '0, 1'b0, ok);
      send(32'h7400, 4'b0010, 1'b0, '0, 1'b0, ok);
      vectors++; if (ok !== 1'b1 || refill_valid_o !== 1'b1 || refill_id_o !== 1'b0) begin miscompares++; $display("FAIL midwrite_entries_free: got ok=%0b rf_v=%0b rf_id=%0d want 1/1/0", ok, refill_valid_o, refill_id_o); end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss();
      test_secondary_miss();
      test_capacity();
      test_error_victim();
      test_rsp_backpressure();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
